// File: rtl/datapath_seq_ctrl.sv
// datapath_seq_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer
// for the single-issue MIPS-style DATAPATH.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN. When it is defined, illegal
// instructions trap to HALT and raise err. When it is undefined, they run as
// a 3-cycle NOP and count as retired.
// Every output is registered. The one exception is pc_en during BEQ EXEC,
// which must follow the live ALU zero flag.
module datapath_seq_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             ir_en,
    output logic             pc_en,
    output logic             pc_src,
    output logic             br,
    output logic             regdst,
    output logic             enable,
    output logic             alusrc,
    output logic [2:0]       aluop,
    output logic             mem_we,
    output logic             busy,
    output logic [CNT_W-1:0] instr_cnt
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    output logic             err
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
`ifdef CTRL_ILLEGAL_TRAP_EN
        ,
        S_HALT   = 3'd6
`endif
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    // Returns 1 when an instruction (opcode plus funct for R-type) is supported.
    function automatic logic instr_ok(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            OP_R: begin
                case (fn)
                    FN_AND, FN_OR, FN_ADD, FN_SUB, FN_SLT: instr_ok = 1'b1;
                    default:                               instr_ok = 1'b0;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW, OP_BEQ: instr_ok = 1'b1;
            default:                       instr_ok = 1'b0;
        endcase
    endfunction

    // Returns the ALU function code of an instruction.
    function automatic logic [2:0] alu_code(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            OP_R: begin
                case (fn)
                    FN_AND:  alu_code = 3'd0;
                    FN_OR:   alu_code = 3'd1;
                    FN_ADD:  alu_code = 3'd2;
                    FN_SUB:  alu_code = 3'd6;
                    FN_SLT:  alu_code = 3'd7;
                    default: alu_code = 3'd0;
                endcase
            end
            OP_BEQ:  alu_code = 3'd6;
            default: alu_code = 3'd2;
        endcase
    endfunction

    state_t           state_r;
    logic [5:0]       op_r;
    logic [5:0]       fn_r;
    logic             ir_en_r, pc_en_r, pc_src_r, br_r, regdst_r, enable_r;
    logic             alusrc_r, mem_we_r, busy_r, beq_exec_r, err_r;
    logic [2:0]       aluop_r;
    logic [CNT_W-1:0] instr_cnt_r;
    logic             legal_s, is_r_s, is_lw_s, is_sw_s, is_beq_s, is_imm_s, last_s;

    // Decodes the latched instruction fields and flags the last cycle of an instruction.
    always_comb begin
        legal_s  = instr_ok(op_r, fn_r);
        is_r_s   = (op_r == OP_R);
        is_lw_s  = (op_r == OP_LW);
        is_sw_s  = (op_r == OP_SW);
        is_beq_s = (op_r == OP_BEQ);
        is_imm_s = (op_r == OP_ADDI) || is_lw_s || is_sw_s;
        last_s   = 1'b0;
        case (state_r)
            S_EXEC:  last_s = is_beq_s || !legal_s;
            S_MEM:   last_s = is_sw_s;
            S_WB:    last_s = 1'b1;
            default: last_s = 1'b0;
        endcase
    end

    // Sequencer: advances the state and registers the control outputs of the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            op_r        <= 6'd0;
            fn_r        <= 6'd0;
            ir_en_r     <= 1'b0;
            pc_en_r     <= 1'b0;
            pc_src_r    <= 1'b0;
            br_r        <= 1'b0;
            regdst_r    <= 1'b0;
            enable_r    <= 1'b0;
            alusrc_r    <= 1'b0;
            aluop_r     <= 3'd0;
            mem_we_r    <= 1'b0;
            busy_r      <= 1'b0;
            beq_exec_r  <= 1'b0;
            err_r       <= 1'b0;
            instr_cnt_r <= {CNT_W{1'b0}};
        end else begin
            // Strobes last exactly one state; alusrc and aluop are held unless reassigned.
            ir_en_r    <= 1'b0;
            pc_en_r    <= 1'b0;
            pc_src_r   <= 1'b0;
            br_r       <= 1'b0;
            regdst_r   <= 1'b0;
            enable_r   <= 1'b0;
            mem_we_r   <= 1'b0;
            beq_exec_r <= 1'b0;
            if (last_s) begin
                instr_cnt_r <= instr_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                alusrc_r    <= 1'b0;
                aluop_r     <= 3'd0;
                if (run) begin
                    state_r <= S_FETCH;
                    ir_en_r <= 1'b1;
                    pc_en_r <= 1'b1;
                    busy_r  <= 1'b1;
                end else begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                end
            end else begin
                case (state_r)
                    S_IDLE: begin
                        if (run) begin
                            state_r <= S_FETCH;
                            ir_en_r <= 1'b1;
                            pc_en_r <= 1'b1;
                            busy_r  <= 1'b1;
                        end else begin
                            state_r <= S_IDLE;
                            busy_r  <= 1'b0;
                        end
                    end
                    S_FETCH: begin
                        // The instruction memory still presents this instruction, so latch it now.
                        state_r <= S_DECODE;
                        op_r    <= opcode;
                        fn_r    <= funct;
                    end
                    S_DECODE: begin
                        if (legal_s) begin
                            state_r    <= S_EXEC;
                            alusrc_r   <= is_imm_s;
                            aluop_r    <= alu_code(op_r, fn_r);
                            pc_src_r   <= is_beq_s;
                            beq_exec_r <= is_beq_s;
                        end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                            state_r  <= S_HALT;
                            err_r    <= 1'b1;
`else
                            state_r  <= S_EXEC;
`endif
                            alusrc_r <= 1'b0;
                            aluop_r  <= 3'd0;
                        end
                    end
                    S_EXEC: begin
                        // Only LW/SW/R/ADDI get here: BEQ and NOP end in EXEC.
                        if (is_lw_s || is_sw_s) begin
                            state_r  <= S_MEM;
                            mem_we_r <= is_sw_s;
                        end else begin
                            state_r  <= S_WB;
                            enable_r <= 1'b1;
                            regdst_r <= is_r_s;
                            br_r     <= 1'b1;
                        end
                    end
                    S_MEM: begin
                        // LW continues to writeback from data memory.
                        state_r  <= S_WB;
                        enable_r <= 1'b1;
                    end
`ifdef CTRL_ILLEGAL_TRAP_EN
                    S_HALT: begin
                        state_r <= S_HALT;
                    end
`endif
                    default: begin
                        state_r  <= S_IDLE;
                        busy_r   <= 1'b0;
                        alusrc_r <= 1'b0;
                        aluop_r  <= 3'd0;
                    end
                endcase
            end
        end
    end

    assign ir_en     = ir_en_r;
    assign pc_en     = beq_exec_r ? zero : pc_en_r;
    assign pc_src    = pc_src_r;
    assign br        = br_r;
    assign regdst    = regdst_r;
    assign enable    = enable_r;
    assign alusrc    = alusrc_r;
    assign aluop     = aluop_r;
    assign mem_we    = mem_we_r;
    assign busy      = busy_r;
    assign instr_cnt = instr_cnt_r;
`ifdef CTRL_ILLEGAL_TRAP_EN
    assign err       = err_r;
`endif

endmodule

// File: tb/tb_datapath_seq_ctrl.sv
// Scoreboard bench for datapath_seq_ctrl: a per-instruction reference model
// pushes the expected control vector of every cycle; a negedge monitor pops and compares.
module tb_datapath_seq_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n, run, zero;
    logic [5:0]    opcode, funct;
    logic          ir_en, pc_en, pc_src, br, regdst, enable, alusrc, mem_we, busy;
    logic [2:0]    aluop;
    logic [CW-1:0] instr_cnt;
    logic          err_act;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic          err;
    assign err_act = err;
`else
    assign err_act = 1'b0;
`endif

    datapath_seq_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .funct(funct), .zero(zero),
        .ir_en(ir_en), .pc_en(pc_en), .pc_src(pc_src), .br(br), .regdst(regdst),
        .enable(enable), .alusrc(alusrc), .aluop(aluop), .mem_we(mem_we), .busy(busy),
        .instr_cnt(instr_cnt)
`ifdef CTRL_ILLEGAL_TRAP_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    logic [12:0]   exp_v[$];
    logic [CW-1:0] exp_c[$];
    int            checks = 0;
    int            errors = 0;
    int            mcnt   = 0;
    bit            in_idle = 1'b1;
    logic [12:0]   mon_ev, mon_act;
    logic [CW-1:0] mon_ec;

    // Expected vector layout: {err, ir_en, pc_en, pc_src, br, regdst, enable, alusrc, aluop, mem_we, busy}
    function automatic logic [12:0] mk(input logic ir, input logic pc, input logic ps, input logic b,
                                       input logic rd, input logic en, input logic as,
                                       input logic [2:0] au, input logic mw, input logic bz,
                                       input logic er);
        return {er, ir, pc, ps, b, rd, en, as, au, mw, bz};
    endfunction

    // Instruction class: 0 R, 1 ADDI, 2 LW, 3 SW, 4 BEQ, 5 illegal
    function automatic int cls_of(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'b000000: return (fn inside {6'b100100, 6'b100101, 6'b100000, 6'b100010, 6'b101010}) ? 0 : 5;
            6'b001000: return 1;
            6'b100011: return 2;
            6'b101011: return 3;
            6'b000100: return 4;
            default:   return 5;
        endcase
    endfunction

    function automatic logic [2:0] au_of(input logic [5:0] op, input logic [5:0] fn);
        case (cls_of(op, fn))
            0: begin
                case (fn)
                    6'b100100: return 3'd0;
                    6'b100101: return 3'd1;
                    6'b100000: return 3'd2;
                    6'b100010: return 3'd6;
                    default:   return 3'd7;
                endcase
            end
            1, 2, 3: return 3'd2;
            4:       return 3'd6;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [5:0] rnd6();
        return 6'($urandom_range(0, 63));
    endfunction

    // Monitor: compares the DUT against the oldest expected cycle
    always @(negedge clk) begin
        if (exp_v.size() > 0) begin
            mon_ev  = exp_v.pop_front();
            mon_ec  = exp_c.pop_front();
            mon_act = {err_act, ir_en, pc_en, pc_src, br, regdst, enable, alusrc, aluop, mem_we, busy};
            checks++;
            if (mon_act !== mon_ev) begin
                errors++;
                $display("FAIL ctrl_vec t=%0t got=%b want=%b", $time, mon_act, mon_ev);
            end
            checks++;
            if (instr_cnt !== mon_ec) begin
                errors++;
                $display("FAIL instr_cnt t=%0t got=%0d want=%0d", $time, instr_cnt, mon_ec);
            end
        end
    end

    // One clock cycle: drive inputs, queue that cycle's expectation, advance
    task automatic cyc(input logic [12:0] ev, input logic [5:0] op, input logic [5:0] fn,
                       input logic rv, input logic zv, input logic rn);
        opcode = op;
        funct  = fn;
        run    = rv;
        zero   = zv;
        rst_n  = rn;
        exp_v.push_back(ev);
        exp_c.push_back(mcnt[CW-1:0]);
        @(posedge clk);
        #1;
    endtask

    // One instruction: mid = run level on non-final cycles (2 = random),
    // zf = zero level (-1 = random), rst_at = cycle index with rst_n low (-1 none)
    task automatic go(input logic [5:0] op, input logic [5:0] fn, input logic run_after,
                      input int rst_at, input int mid, input int zf);
        int          c, n, last;
        logic [2:0]  au;
        logic        as, rv, rn;
        logic [12:0] sv[$];
        logic        zs[5];
        if (in_idle) begin
            n = $urandom_range(0, 2);
            for (int i = 0; i < n; i++)
                cyc(13'd0, rnd6(), rnd6(), 1'b0, rbit(), 1'b1);
            cyc(13'd0, op, fn, 1'b1, rbit(), 1'b1);
        end
        for (int i = 0; i < 5; i++)
            zs[i] = (zf < 0) ? rbit() : (zf != 0);
        c  = cls_of(op, fn);
        au = au_of(op, fn);
        as = (c >= 1 && c <= 3);
        sv.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0));
        sv.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0));
        if (c == 5) begin
            sv.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0));
        end else begin
            sv.push_back(mk(1'b0, (c == 4) ? zs[2] : 1'b0, c == 4, 1'b0, 1'b0, 1'b0, as, au,
                            1'b0, 1'b1, 1'b0));
            if (c == 2 || c == 3)
                sv.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, as, au, c == 3, 1'b1, 1'b0));
            if (c <= 2)
                sv.push_back(mk(1'b0, 1'b0, 1'b0, c != 2, c == 0, 1'b1, as, au, 1'b0, 1'b1, 1'b0));
        end
        last = sv.size() - 1;
        for (int k = 0; k <= last; k++) begin
            rv = (k == last) ? run_after : ((mid == 2) ? rbit() : (mid != 0));
            rn = (k != rst_at);
            cyc(sv[k], (k < 2) ? op : rnd6(), (k < 2) ? fn : rnd6(), rv, zs[k], rn);
            if (!rn) begin
                mcnt = 0;
                break;
            end
            if (k == last) mcnt++;
        end
        in_idle = !run_after || (rst_at >= 0 && rst_at <= last);
    endtask

`ifdef CTRL_ILLEGAL_TRAP_EN
    // Illegal opcode traps: FETCH, DECODE, then HALT held with run=1 until reset
    task automatic trap_test();
        logic [12:0] hv;
        hv = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
        cyc(13'd0, 6'b111111, 6'd0, 1'b1, 1'b0, 1'b1);
        cyc(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0),
            6'b111111, 6'd0, 1'b1, 1'b0, 1'b1);
        cyc(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0),
            6'b111111, 6'd0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++)
            cyc(hv, rnd6(), rnd6(), 1'b1, rbit(), 1'b1);
        cyc(hv, rnd6(), rnd6(), 1'b1, rbit(), 1'b0);
        mcnt    = 0;
        in_idle = 1'b1;
    endtask
`endif

    logic [5:0] fl [5] = '{6'b100100, 6'b100101, 6'b100000, 6'b100010, 6'b101010};

    // Random instruction of a random class; illegal ones only without the trap
    task automatic rand_instr(output logic [5:0] op, output logic [5:0] fn);
        int r;
`ifdef CTRL_ILLEGAL_TRAP_EN
        r = $urandom_range(0, 4);
`else
        r = $urandom_range(0, 6);
`endif
        fn = rnd6();
        case (r)
            0: begin op = 6'b000000; fn = fl[$urandom_range(0, 4)]; end
            1: op = 6'b001000;
            2: op = 6'b100011;
            3: op = 6'b101011;
            4: op = 6'b000100;
            5: begin
                op = 6'b000000;
                while (fn inside {6'b100100, 6'b100101, 6'b100000, 6'b100010, 6'b101010}) fn = rnd6();
            end
            default: begin
                op = rnd6();
                while (op inside {6'b000000, 6'b001000, 6'b100011, 6'b101011, 6'b000100}) op = rnd6();
            end
        endcase
    endtask

    // Stimulus: directed scenarios then randomized instruction stream
    initial begin
        logic [5:0] op, fn;
        rst_n  = 1'b0;
        run    = 1'b0;
        zero   = 1'b0;
        opcode = 6'd0;
        funct  = 6'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        go(6'b000000, 6'b100000, 1'b1, -1, 1, -1);  // R ADD
        go(6'b100011, rnd6(), 1'b1, -1, 1, -1);     // LW
        go(6'b101011, rnd6(), 1'b1, -1, 1, -1);     // SW back-to-back
        go(6'b000100, rnd6(), 1'b1, -1, 1, 1);      // BEQ taken
        go(6'b000100, rnd6(), 1'b1, -1, 1, 0);      // BEQ not taken
        go(6'b100011, rnd6(), 1'b0, -1, 0, -1);     // LW with run dropped
        go(6'b000000, 6'b101010, 1'b1, -1, 1, -1);  // resume with SLT
        go(6'b101011, rnd6(), 1'b1, 3, 1, -1);      // reset during SW MEM
`ifdef CTRL_ILLEGAL_TRAP_EN
        go(6'b001000, rnd6(), 1'b0, -1, 1, -1);
        trap_test();
`else
        go(6'b111111, rnd6(), 1'b1, -1, 1, -1);     // illegal opcode NOP
        go(6'b001000, rnd6(), 1'b1, -1, 1, -1);
`endif
        for (int i = 0; i < 250; i++) begin
            rand_instr(op, fn);
            go(op, fn, $urandom_range(0, 3) != 0,
               ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 4)) : -1, 2, -1);
        end
        checks++;
        if (exp_v.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d want=0", exp_v.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #1000000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
